md5_stream_ctrl: RTL and testbench

- Sequencing front-end for the fixed-latency, non-stallable md5core pipeline (448-bit message, 64-bit bit-length in; 128-bit hash out; no valid/stall signals of its own).
- Accepts hash requests over a valid/ready handshake and drives them into the core.
- Tracks each in-flight request with a tag token through a shift register matched to core latency, and captures completed hashes into an output FIFO with valid/ready.
- Credit-based admission guarantees no result is ever dropped, since the core cannot be stalled.

---
 rtl/md5_stream_ctrl_if.sv | 32 +++
 rtl/md5_stream_ctrl.sv | 85 ++++++++
 tb/tb_md5_stream_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/md5_stream_ctrl_if.sv
// md5_stream_ctrl_if: request, core and result signals of the md5 stream controller.
interface md5_stream_ctrl_if #(
   parameter int TAG_W      = 8,
   parameter int FIFO_DEPTH = 80
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic             in_valid;
   logic             in_ready;
   logic [447:0]     in_message;
   logic [63:0]      in_length;
   logic [TAG_W-1:0] in_tag;
   logic [447:0]     core_message;
   logic [63:0]      core_length;
   logic [127:0]     core_hash;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_hash;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;
   logic [CW-1:0]    credits_used;
   logic             busy;
   modport master (
      output in_valid, in_message, in_length, in_tag, core_hash, out_ready,
      input  in_ready, core_message, core_length, out_valid, out_hash, out_tag, out_err,
             credits_used, busy
   );
   modport slave (
      input  in_valid, in_message, in_length, in_tag, core_hash, out_ready,
      output in_ready, core_message, core_length, out_valid, out_hash, out_tag, out_err,
             credits_used, busy
   );
endinterface

// File: rtl/md5_stream_ctrl.sv
// md5_stream_ctrl: credit-admitted front-end for the non-stallable md5core pipeline.
// Tags ride a token shift register matched to core latency; results land in a FWFT FIFO.
module md5_stream_ctrl #(
   parameter int CORE_LATENCY = 66,
   parameter int FIFO_DEPTH   = 80,
   parameter int TAG_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   md5_stream_ctrl_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

   logic                    w_accept, w_err_in, w_wr, w_pop, w_ready, w_valid;
   logic [CORE_LATENCY-1:0] r_tok_v, r_tok_e;
   logic [TAG_W-1:0]        r_tok_t [CORE_LATENCY];
   logic [127:0]            r_mem_h [FIFO_DEPTH];
   logic [TAG_W-1:0]        r_mem_t [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   r_mem_e;
   logic [PW-1:0]           r_wp, r_rp;
   logic [CW-1:0]           r_cnt, r_credits;

   assign w_err_in         = bus.in_length > 64'd447;
   assign w_ready          = r_credits < DEPTH_C;
   assign w_accept         = bus.in_valid & w_ready;
   assign w_wr             = r_tok_v[CORE_LATENCY-1];
   assign w_valid          = r_cnt != '0;
   assign w_pop            = w_valid & bus.out_ready;
   assign bus.in_ready     = w_ready;
   // Over-length requests still run through the core, but as a zero-length message.
   assign bus.core_message = w_accept ? bus.in_message : '0;
   assign bus.core_length  = (w_accept && !w_err_in) ? bus.in_length : '0;
   assign bus.out_valid    = w_valid;
   assign bus.out_hash     = w_valid ? r_mem_h[r_rp] : '0;
   assign bus.out_tag      = w_valid ? r_mem_t[r_rp] : '0;
   assign bus.out_err      = w_valid & r_mem_e[r_rp];
   assign bus.credits_used = r_credits;
   assign bus.busy         = r_credits != '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tok_v <= '0;
         r_tok_e <= '0;
         for (int i = 0; i < CORE_LATENCY; i++) r_tok_t[i] <= '0;
      end else begin
         r_tok_v[0] <= w_accept;
         r_tok_e[0] <= w_err_in;
         r_tok_t[0] <= bus.in_tag;
         for (int i = 1; i < CORE_LATENCY; i++) begin
            r_tok_v[i] <= r_tok_v[i-1];
            r_tok_e[i] <= r_tok_e[i-1];
            r_tok_t[i] <= r_tok_t[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_credits <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp == LAST_P ? '0 : r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp == LAST_P ? '0 : r_rp + 1'b1;
         r_cnt     <= r_cnt + CW'(w_wr) - CW'(w_pop);
         r_credits <= r_credits + CW'(w_accept) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_h[r_wp] <= bus.core_hash;
         r_mem_t[r_wp] <= r_tok_t[CORE_LATENCY-1];
         r_mem_e[r_wp] <= r_tok_e[CORE_LATENCY-1];
      end
   end

   // Credits must make a capture into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_wr && !w_pop && r_cnt == DEPTH_C));
endmodule

// File: tb/tb_md5_stream_ctrl.sv
// tb_md5_stream_ctrl: vector table, directed corner sequences and a random run checked
// against a queue-based reference model, on a depth-80 and a depth-4 controller.
module tb_md5_stream_ctrl;
   localparam int LAT = 66;

   typedef struct packed { logic [31:0] due; logic [127:0] h; logic [7:0] t; logic e; } res_t;
   typedef struct { logic [63:0] len; logic [7:0] tag; logic [63:0] clen; logic [127:0] hash; logic err; } vec_t;

   logic clk = 1'b0, rst_n = 1'b1;
   int tests = 0, fails = 0, cyc = 0;
   res_t pq [2][$];
   res_t fq [2][$];
   logic [127:0] core_a [LAT];
   logic [127:0] core_b [LAT];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   md5_stream_ctrl_if #(.TAG_W(8), .FIFO_DEPTH(80)) ia ();
   md5_stream_ctrl_if #(.TAG_W(8), .FIFO_DEPTH(4))  ib ();
   md5_stream_ctrl #(.CORE_LATENCY(LAT), .FIFO_DEPTH(80), .TAG_W(8)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
   md5_stream_ctrl #(.CORE_LATENCY(LAT), .FIFO_DEPTH(4),  .TAG_W(8)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

   // Stub core: LAT-stage delay of the replicated low length word.
   always @(posedge clk) begin
      core_a[0] <= {4{ia.core_length[31:0]}};
      core_b[0] <= {4{ib.core_length[31:0]}};
      for (int i = 1; i < LAT; i++) begin
         core_a[i] <= core_a[i-1];
         core_b[i] <= core_b[i-1];
      end
   end
   assign ia.core_hash = core_a[LAT-1];
   assign ib.core_hash = core_b[LAT-1];

   function automatic logic [127:0] exp_hash(input logic [63:0] len);
      return len > 64'd447 ? 128'h0 : {4{len[31:0]}};
   endfunction

   task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: requests wait LAT edges in a pipe queue, then join a result queue.
   task automatic step(input int k, input logic rdy, vld, err, bsy, input int cr,
                       input logic [127:0] h, input logic [7:0] t, input logic acc, pop,
                       input logic [63:0] len, input logic [7:0] itag);
      int n, dep;
      logic ok;
      res_t r, hd;
      dep = k == 0 ? 80 : 4;
      n = pq[k].size() + fq[k].size();
      hd = '0;
      if (fq[k].size() != 0) hd = fq[k][0];
      ok = rdy == (n < dep) && cr == n && bsy == (n != 0) && vld == (fq[k].size() != 0);
      if (fq[k].size() != 0) ok = ok && h == hd.h && t == hd.t && err == hd.e;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL scoreboard[%0d] cyc=%0d: got rdy=%b vld=%b cr=%0d busy=%b head=%h/%h/%b, expected rdy=%b vld=%b cr=%0d head=%h/%h/%b",
                  k, cyc, rdy, vld, cr, bsy, h, t, err, n < dep, fq[k].size() != 0, n, hd.h, hd.t, hd.e);
      end
      if (acc) begin
         r.due = 32'(cyc + 1 + LAT);
         r.h = exp_hash(len);
         r.t = itag;
         r.e = len > 64'd447;
         pq[k].push_back(r);
      end
      if (pop && fq[k].size() != 0) void'(fq[k].pop_front());
      while (pq[k].size() != 0 && pq[k][0].due == 32'(cyc + 1)) fq[k].push_back(pq[k].pop_front());
   endtask

   always @(negedge rst_n) for (int k = 0; k < 2; k++) begin pq[k].delete(); fq[k].delete(); end

   always @(negedge clk) if (rst_n) begin
      step(0, ia.in_ready, ia.out_valid, ia.out_err, ia.busy, int'(ia.credits_used), ia.out_hash, ia.out_tag,
           ia.in_valid & ia.in_ready, ia.out_valid & ia.out_ready, ia.in_length, ia.in_tag);
      step(1, ib.in_ready, ib.out_valid, ib.out_err, ib.busy, int'(ib.credits_used), ib.out_hash, ib.out_tag,
           ib.in_valid & ib.in_ready, ib.out_valid & ib.out_ready, ib.in_length, ib.in_tag);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vt [8];
      logic [447:0] msg;
      int got, gaps, drops, bad, acc, seen;
      vt[0] = '{64'd24,           8'h5A, 64'd24,  128'h00000018_00000018_00000018_00000018, 1'b0};
      vt[1] = '{64'd448,          8'h11, 64'd0,   128'h0,            1'b1};
      vt[2] = '{64'd447,          8'h22, 64'd447, {4{32'h1BF}},      1'b0};
      vt[3] = '{64'd0,            8'h33, 64'd0,   128'h0,            1'b0};
      vt[4] = '{64'h1_0000_0005,  8'h44, 64'd0,   128'h0,            1'b1};
      vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h55, 64'd0, 128'h0,       1'b1};
      vt[6] = '{64'd1,            8'h66, 64'd1,   {4{32'h1}},        1'b0};
      vt[7] = '{64'd256,          8'hA5, 64'd256, {4{32'h100}},      1'b0};
      {ia.in_valid, ia.in_message, ia.in_length, ia.in_tag, ia.out_ready} = '0;
      {ib.in_valid, ib.in_message, ib.in_length, ib.in_tag, ib.out_ready} = '0;

      #1 rst_n = 1'b0;
      #2;
      chk("rst flags A", {ia.in_ready, ia.out_valid, ia.out_err, ia.busy}, 4'b1000);
      chk("rst credits A", ia.credits_used, 0);
      chk("rst hash/tag A", {ia.out_hash, ia.out_tag}, 0);
      chk("rst flags B", {ib.in_ready, ib.out_valid, ib.out_err, ib.busy}, 4'b1000);
      chk("rst credits B", ib.credits_used, 0);
      #19 rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         tick();
         for (int j = 0; j < 14; j++) msg[j*32 +: 32] = $urandom;
         ia.in_valid = 1'b1; ia.in_message = msg; ia.in_length = vt[v].len; ia.in_tag = vt[v].tag;
         #1;
         chk($sformatf("in_ready[%0d]", v), ia.in_ready, 1);
         chk($sformatf("core_length[%0d]", v), ia.core_length, vt[v].clen);
         chk($sformatf("core_message[%0d]", v), ia.core_message, msg);
         tick();
         ia.in_valid = 1'b0;
         #1 chk($sformatf("core idle[%0d]", v), {ia.core_message != '0, ia.core_length != '0}, 0);
         repeat (LAT - 1) tick();
         chk($sformatf("early valid[%0d]", v), ia.out_valid, 0);
         tick();
         chk($sformatf("out_valid[%0d]", v), ia.out_valid, 1);
         chk($sformatf("out_hash[%0d]", v), ia.out_hash, vt[v].hash);
         chk($sformatf("out_tag/err[%0d]", v), {ia.out_tag, ia.out_err}, {vt[v].tag, vt[v].err});
         chk($sformatf("credits[%0d]", v), ia.credits_used, 1);
         ia.out_ready = 1'b1;
         tick();
         ia.out_ready = 1'b0;
         chk($sformatf("busy after pop[%0d]", v), {ia.busy, ia.out_valid}, 0);
      end

      got = 0; gaps = 0; drops = 0; bad = 0;
      ia.out_ready = 1'b1;
      for (int c = 0; c < 200 + LAT + 10; c++) begin
         tick();
         if (ia.out_valid) begin
            if (ia.out_tag !== 8'(got) || ia.out_hash !== {4{32'(got)}}) bad++;
            got++;
         end else if (got > 0 && got < 200) gaps++;
         ia.in_valid = c < 200;
         ia.in_length = 64'(c);
         ia.in_tag = 8'(c);
         if (c < 200 && !ia.in_ready) drops++;
      end
      ia.in_valid = 1'b0; ia.out_ready = 1'b0;
      chk("stream count", got, 200);
      chk("stream gaps", gaps, 0);
      chk("stream ready drops", drops, 0);
      chk("stream data", bad, 0);

      tick();
      ia.in_valid = 1'b1; ia.in_length = 64'd5; ia.in_tag = 8'hC1;
      tick();
      ia.in_length = 64'd6; ia.in_tag = 8'hC2;
      tick();
      ia.in_valid = 1'b0;
      repeat (LAT - 1) tick();
      chk("one entry head", {ia.out_valid, ia.out_tag}, {1'b1, 8'hC1});
      chk("one entry credits", ia.credits_used, 2);
      ia.out_ready = 1'b1;
      tick();
      ia.out_ready = 1'b0;
      chk("capture+pop head", {ia.out_valid, ia.out_tag}, {1'b1, 8'hC2});
      chk("capture+pop hash", ia.out_hash, {4{32'd6}});
      chk("capture+pop credits", ia.credits_used, 1);
      ia.out_ready = 1'b1;
      tick();
      ia.out_ready = 1'b0;
      chk("capture+pop drained", {ia.out_valid, ia.busy}, 0);

      for (int c = 0; c < 30; c++) begin
         tick();
         ia.in_valid = c < 10; ia.in_length = 64'(100 + c); ia.in_tag = 8'(c);
      end
      chk("pre-reset credits", ia.credits_used, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset out_valid", ia.out_valid, 0);
      chk("mid reset credits", ia.credits_used, 0);
      chk("mid reset ready/busy", {ia.in_ready, ia.busy}, 2'b10);
      rst_n = 1'b1;
      seen = 0;
      repeat (100) begin tick(); if (ia.out_valid) seen++; end
      chk("no stale results", seen, 0);

      acc = 0;
      for (int c = 0; c < 75; c++) begin
         tick();
         ib.in_valid = 1'b1; ib.in_length = 64'(10 + c); ib.in_tag = 8'(8'h80 + c);
         if (ib.in_ready) acc++;
         if (c == 5) chk("bp credits early", ib.credits_used, 4);
      end
      chk("bp accepts", acc, 4);
      chk("bp full", {ib.in_ready, ib.out_valid, ib.credits_used}, {1'b0, 1'b1, 3'd4});
      ib.out_ready = 1'b1;
      #1 chk("bp ready not comb", ib.in_ready, 0);
      tick();
      ib.out_ready = 1'b0;
      chk("bp ready after pop", {ib.in_ready, ib.credits_used}, {1'b1, 3'd3});
      acc++;
      tick();
      chk("bp refilled", {ib.in_ready, ib.credits_used}, {1'b0, 3'd4});
      repeat (20) begin tick(); if (ib.in_ready) acc++; end
      chk("bp one more accept", acc, 5);
      ib.in_valid = 1'b0; ib.out_ready = 1'b1;
      repeat (LAT + 10) tick();
      chk("bp drained", ib.busy, 0);

      for (int c = 0; c < 2000; c++) begin
         tick();
         ia.in_valid = $urandom_range(0, 9) < 7;
         ia.in_length = $urandom_range(0, 3) == 0 ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 500));
         ia.in_tag = 8'($urandom);
         ia.out_ready = $urandom_range(0, 9) < 6;
         ib.in_valid = $urandom_range(0, 9) < 7;
         ib.in_length = 64'($urandom_range(0, 520));
         ib.in_tag = 8'($urandom);
         ib.out_ready = $urandom_range(0, 9) < 4;
      end
      ia.in_valid = 1'b0; ia.out_ready = 1'b1;
      ib.in_valid = 1'b0; ib.out_ready = 1'b1;
      repeat (LAT + 90) tick();
      chk("random drained A", ia.busy, 0);
      chk("random drained B", ib.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
